match_sequencer: RTL and testbench
==================================

// Module: match_sequencer
//
// PURPOSE
//   Top-level match controller for pong: sequences IDLE -> SERVE -> RALLY -> POINT ... -> OVER.
//   Owns both score registers and tells the game datapath when to freeze the ball, re-centre it,
//   enable the paddles and which way to serve. Sits beside the game datapath, fed by the key
//   inputs, the per-frame strobe and the datapath's goal-detect pulses.
//
// PARAMETERS
//   M_SCORE_W     4   score register width
//   WIN_SCORE     5   points needed to win; 1 <= WIN_SCORE <= 2**M_SCORE_W-1
//   SERVE_FRAMES  60  frames ball is held at centre before release (>=1)
//   POINT_FRAMES  30  frames of freeze after a goal (>=1)
//   CNT_W         8   frame counter width; must hold max(SERVE_FRAMES,POINT_FRAMES)
//
// PORTS
//   clk_i            in   1          system clock
//   rst_i            in   1          async reset, active-high
//   new_frame_i      in   1          1-cycle pulse per video frame
//   start_i          in   1          start key, level; rising edge detected internally
//   pause_i          in   1          pause key, level; rising edge toggles pause
//   p_goal_i         in   1          1-cycle pulse: player scored
//   e_goal_i         in   1          1-cycle pulse: enemy scored
//   ball_freeze_o    out  1          1 = datapath must not advance ball
//   ball_recenter_o  out  1          1-cycle pulse: load ball to centre, new serve speed
//   paddles_en_o     out  1          1 = paddle updates allowed
//   serve_dir_o      out  1          0 = serve toward enemy, 1 = toward player
//   p_score_o        out  M_SCORE_W  player score
//   e_score_o        out  M_SCORE_W  enemy score
//   winner_o         out  2          00 none, 01 player, 10 enemy
//   state_o          out  3          current state encoding (debug/score display)
//
// BEHAVIOUR
//   - Reset (async): state IDLE, scores 0, counter 0, serve_dir_o 0, winner_o 00,
//     ball_freeze_o 1, ball_recenter_o 0, paddles_en_o 0; start/pause edge regs reset to 1
//     (key held through reset gives no edge). Reset mid-match aborts immediately.
//   - All outputs registered/Moore; state changes 1 clk after the triggering input is sampled.
//   - States: IDLE=0 SERVE=1 RALLY=2 POINT=3 PAUSED=4 OVER=5; 6,7 -> IDLE next clk.
//   - IDLE: freeze=1, paddles=0. start edge -> SERVE, scores cleared, serve_dir 0.
//   - SERVE entry: recenter pulse (1 clk), counter=0. freeze=1, paddles=1. Counter increments on
//     new_frame_i; new_frame_i while counter==SERVE_FRAMES-1 -> RALLY.
//   - RALLY: freeze=0, paddles=1. p_goal_i: p_score+1, serve_dir<=1; e_goal_i: e_score+1,
//     serve_dir<=0. Both same clk: player has priority, e_goal_i dropped. If incremented score
//     == WIN_SCORE -> OVER, winner_o set; else -> POINT.
//   - POINT entry: counter=0. freeze=1, paddles=0. After POINT_FRAMES frames -> SERVE.
//   - PAUSED: entered by pause edge from SERVE or RALLY only (edge ignored elsewhere); return
//     state stored. freeze=1, paddles=0, counter frozen, no recenter. Pause edge -> return state,
//     counter resumes from held value. start edge in PAUSED ignored.
//   - OVER: freeze=1, paddles=0, scores and winner held. start edge -> SERVE, scores 0, winner 00.
//   - Goal pulses outside RALLY ignored. Scores never exceed WIN_SCORE; no wrap.
//   - Simultaneous start and pause edges: start evaluated only in IDLE/OVER, pause only in
//     SERVE/RALLY/PAUSED, so no conflict.
//
// TESTING
//   1 Reset, start held high through reset release -> stays IDLE; release then press -> SERVE,
//     recenter pulse exactly 1 clk.
//   2 SERVE with 60 new_frame pulses -> RALLY on clk after 60th pulse, freeze 1->0; 59 -> still SERVE.
//   3 RALLY, p_goal -> p_score=1, serve_dir=1, POINT; 30 frames later SERVE + recenter pulse.
//   4 p_goal and e_goal same clk at 2:2 -> 3:2, POINT; goal pulses during POINT/SERVE -> no change.
//   5 Pause edge at SERVE frame 20 -> PAUSED, 100 frames ignored; pause edge -> SERVE, RALLY after
//     40 more frames.
//   6 Score 4:0, p_goal -> 5:0, OVER, winner 01; extra goals ignored; start edge -> SERVE, 0:0, 00;
//     assert rst_i mid-RALLY -> IDLE outputs same clk.

Source files
------------

// File: rtl/match_sequencer.sv
// Pong match controller: IDLE -> SERVE -> RALLY -> POINT ... -> OVER, owns both scores.
// Latency: every output is registered; a sampled input shows up on the outputs one clk later.
// Backpressure: none; frame strobes and goal pulses are consumed in the clk they arrive or dropped.
//
// Ports:
//   clk_i, rst_i (async, active-high)
//   new_frame_i  per-frame strobe        start_i/pause_i  key levels, rising edge acts
//   p_goal_i/e_goal_i  datapath goal pulses
//   ball_freeze_o, ball_recenter_o, paddles_en_o, serve_dir_o  datapath control
//   p_score_o, e_score_o, winner_o, state_o                    score / debug display
module match_sequencer #(
  parameter int M_SCORE_W    = 4,
  parameter int WIN_SCORE    = 5,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30,
  parameter int CNT_W        = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 new_frame_i,
  input  logic                 start_i,
  input  logic                 pause_i,
  input  logic                 p_goal_i,
  input  logic                 e_goal_i,
  output logic                 ball_freeze_o,
  output logic                 ball_recenter_o,
  output logic                 paddles_en_o,
  output logic                 serve_dir_o,
  output logic [M_SCORE_W-1:0] p_score_o,
  output logic [M_SCORE_W-1:0] e_score_o,
  output logic [1:0]           winner_o,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SERVE  = 3'd1,
    ST_RALLY  = 3'd2,
    ST_POINT  = 3'd3,
    ST_PAUSED = 3'd4,
    ST_OVER   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0]     SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]     POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [M_SCORE_W-1:0] WIN_SC     = M_SCORE_W'(WIN_SCORE);

  state_t               state_q, state_d;
  state_t               ret_q, ret_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [M_SCORE_W-1:0] p_score_d, e_score_d;
  logic [M_SCORE_W-1:0] p_inc, e_inc;
  logic                 dir_d;
  logic [1:0]           winner_d;
  logic                 recenter_d;
  logic                 start_q, pause_q;
  logic                 start_edge, pause_edge;

  // Edge registers reset to 1 so a key held through reset does not count as a press.
  assign start_edge = start_i & ~start_q;
  assign pause_edge = pause_i & ~pause_q;

  assign p_inc   = p_score_o + 1'b1;
  assign e_inc   = e_score_o + 1'b1;
  assign state_o = state_q;

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    cnt_d      = cnt_q;
    p_score_d  = p_score_o;
    e_score_d  = e_score_o;
    dir_d      = serve_dir_o;
    winner_d   = winner_o;
    recenter_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d    = ST_SERVE;
          cnt_d      = '0;
          p_score_d  = '0;
          e_score_d  = '0;
          dir_d      = 1'b0;
          recenter_d = 1'b1;
        end
      end

      ST_SERVE: begin
        // A pause press wins over a simultaneous frame strobe: the count stays put.
        if (pause_edge) begin
          state_d = ST_PAUSED;
          ret_d   = ST_SERVE;
        end else if (new_frame_i) begin
          if (cnt_q == SERVE_LAST) begin
            state_d = ST_RALLY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_RALLY: begin
        // Goals outrank a pause press in the same clk so no point is ever lost;
        // the player goal outranks the enemy goal.
        if (p_goal_i) begin
          p_score_d = p_inc;
          dir_d     = 1'b1;
          cnt_d     = '0;
          if (p_inc == WIN_SC) begin
            state_d  = ST_OVER;
            winner_d = 2'b01;
          end else begin
            state_d = ST_POINT;
          end
        end else if (e_goal_i) begin
          e_score_d = e_inc;
          dir_d     = 1'b0;
          cnt_d     = '0;
          if (e_inc == WIN_SC) begin
            state_d  = ST_OVER;
            winner_d = 2'b10;
          end else begin
            state_d = ST_POINT;
          end
        end else if (pause_edge) begin
          state_d = ST_PAUSED;
          ret_d   = ST_RALLY;
        end
      end

      ST_POINT: begin
        if (new_frame_i) begin
          if (cnt_q == POINT_LAST) begin
            state_d    = ST_SERVE;
            cnt_d      = '0;
            recenter_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_PAUSED: begin
        // Resume without recentering; the counter keeps the value it had.
        if (pause_edge) begin
          state_d = ret_q;
        end
      end

      ST_OVER: begin
        if (start_edge) begin
          state_d    = ST_SERVE;
          cnt_d      = '0;
          p_score_d  = '0;
          e_score_d  = '0;
          winner_d   = 2'b00;
          dir_d      = 1'b0;
          recenter_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      ret_q           <= ST_IDLE;
      cnt_q           <= '0;
      p_score_o       <= '0;
      e_score_o       <= '0;
      serve_dir_o     <= 1'b0;
      winner_o        <= 2'b00;
      ball_freeze_o   <= 1'b1;
      ball_recenter_o <= 1'b0;
      paddles_en_o    <= 1'b0;
      start_q         <= 1'b1;
      pause_q         <= 1'b1;
    end else begin
      state_q         <= state_d;
      ret_q           <= ret_d;
      cnt_q           <= cnt_d;
      p_score_o       <= p_score_d;
      e_score_o       <= e_score_d;
      serve_dir_o     <= dir_d;
      winner_o        <= winner_d;
      ball_freeze_o   <= (state_d != ST_RALLY);
      ball_recenter_o <= recenter_d;
      paddles_en_o    <= (state_d == ST_SERVE) || (state_d == ST_RALLY);
      start_q         <= start_i;
      pause_q         <= pause_i;
    end
  end

endmodule

// File: tb/tb_match_sequencer.sv
module tb_match_sequencer;

  localparam int SW  = 4;
  localparam int WIN = 5;
  localparam int SF  = 60;
  localparam int PF  = 30;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          new_frame_i, start_i, pause_i, p_goal_i, e_goal_i;
  logic          ball_freeze_o, ball_recenter_o, paddles_en_o, serve_dir_o;
  logic [SW-1:0] p_score_o, e_score_o;
  logic [1:0]    winner_o;
  logic [2:0]    state_o;

  match_sequencer #(
    .M_SCORE_W(SW), .WIN_SCORE(WIN), .SERVE_FRAMES(SF), .POINT_FRAMES(PF), .CNT_W(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .new_frame_i(new_frame_i), .start_i(start_i),
    .pause_i(pause_i), .p_goal_i(p_goal_i), .e_goal_i(e_goal_i),
    .ball_freeze_o(ball_freeze_o), .ball_recenter_o(ball_recenter_o),
    .paddles_en_o(paddles_en_o), .serve_dir_o(serve_dir_o),
    .p_score_o(p_score_o), .e_score_o(e_score_o), .winner_o(winner_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_bad   = 0;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input int st, input int ps, input int es,
                           input int dir, input int frz, input int pad, input int rec,
                           input int win);
    chk({tag, ".state"},    int'(state_o),         st);
    chk({tag, ".p_score"},  int'(p_score_o),       ps);
    chk({tag, ".e_score"},  int'(e_score_o),       es);
    chk({tag, ".dir"},      int'(serve_dir_o),     dir);
    chk({tag, ".freeze"},   int'(ball_freeze_o),   frz);
    chk({tag, ".paddles"},  int'(paddles_en_o),    pad);
    chk({tag, ".recenter"}, int'(ball_recenter_o), rec);
    chk({tag, ".winner"},   int'(winner_o),        win);
  endtask

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic cyc(input logic s, input logic p, input logic f, input logic g1, input logic g2);
    start_i = s; pause_i = p; new_frame_i = f; p_goal_i = g1; e_goal_i = g2;
    @(posedge clk_i);
    #1;
  endtask

  task automatic frames(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // ---------------- reference model (countdown of remaining frames) ----------------
  int   m_state, m_left, m_ret, m_p, m_e, m_dir, m_win, m_rec;
  logic m_sp, m_pp;

  function automatic void model_reset();
    m_state = 0; m_left = 0; m_ret = 0; m_p = 0; m_e = 0;
    m_dir = 0; m_win = 0; m_rec = 0; m_sp = 1'b1; m_pp = 1'b1;
  endfunction

  function automatic void model_serve();
    m_state = 1; m_left = SF; m_rec = 1;
  endfunction

  function automatic void model_step(input logic s, input logic p, input logic f,
                                     input logic g1, input logic g2);
    logic se, pe;
    se = s & ~m_sp;
    pe = p & ~m_pp;
    m_sp = s;
    m_pp = p;
    m_rec = 0;
    case (m_state)
      0: if (se) begin model_serve(); m_p = 0; m_e = 0; m_dir = 0; end
      1: if (pe) begin m_ret = 1; m_state = 4; end
         else if (f) begin m_left--; if (m_left == 0) m_state = 2; end
      2: if (g1) begin
           m_p++; m_dir = 1;
           if (m_p == WIN) begin m_state = 5; m_win = 1; end
           else begin m_state = 3; m_left = PF; end
         end else if (g2) begin
           m_e++; m_dir = 0;
           if (m_e == WIN) begin m_state = 5; m_win = 2; end
           else begin m_state = 3; m_left = PF; end
         end else if (pe) begin m_ret = 2; m_state = 4; end
      3: if (f) begin m_left--; if (m_left == 0) model_serve(); end
      4: if (pe) m_state = m_ret;
      5: if (se) begin model_serve(); m_p = 0; m_e = 0; m_win = 0; m_dir = 0; end
      default: m_state = 0;
    endcase
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    int   reps;
    logic s, p, f, g1, g2;
    int   st, ps, es, dir, frz, pad, rec, win;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [16:0] got_v, exp_v;
    logic        rs, rp, rf, rg1, rg2;
    int          rnd_bad;

    //          reps s  p  f  g1 g2  st ps es dir frz pad rec win
    tbl[0]  = '{3,   1, 0, 0, 0, 0,  0, 0, 0, 0,  1,  0,  0,  0};  // start held through reset
    tbl[1]  = '{1,   0, 0, 0, 0, 0,  0, 0, 0, 0,  1,  0,  0,  0};
    tbl[2]  = '{1,   1, 0, 0, 0, 0,  1, 0, 0, 0,  1,  1,  1,  0};  // press -> SERVE + recenter
    tbl[3]  = '{1,   1, 0, 0, 0, 0,  1, 0, 0, 0,  1,  1,  0,  0};  // recenter is one clk
    tbl[4]  = '{59,  0, 0, 1, 0, 0,  1, 0, 0, 0,  1,  1,  0,  0};  // 59 frames: still SERVE
    tbl[5]  = '{1,   0, 0, 1, 0, 0,  2, 0, 0, 0,  0,  1,  0,  0};  // 60th frame -> RALLY
    tbl[6]  = '{1,   0, 0, 0, 1, 0,  3, 1, 0, 1,  1,  0,  0,  0};  // player goal
    tbl[7]  = '{29,  0, 0, 1, 0, 0,  3, 1, 0, 1,  1,  0,  0,  0};
    tbl[8]  = '{1,   0, 0, 1, 0, 0,  1, 1, 0, 1,  1,  1,  1,  0};  // 30th frame -> SERVE
    tbl[9]  = '{1,   0, 0, 0, 1, 1,  1, 1, 0, 1,  1,  1,  0,  0};  // goals in SERVE ignored
    tbl[10] = '{60,  0, 0, 1, 0, 0,  2, 1, 0, 1,  0,  1,  0,  0};
    tbl[11] = '{1,   0, 0, 0, 0, 1,  3, 1, 1, 0,  1,  0,  0,  0};  // enemy goal
    tbl[12] = '{1,   0, 0, 0, 1, 0,  3, 1, 1, 0,  1,  0,  0,  0};  // goal in POINT ignored

    rst_i = 1'b1;
    start_i = 1'b1; pause_i = 1'b0; new_frame_i = 1'b0; p_goal_i = 1'b0; e_goal_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_all("reset", 0, 0, 0, 0, 1, 0, 0, 0);
    rst_i = 1'b0;

    for (int i = 0; i < 13; i++) begin
      repeat (tbl[i].reps) cyc(tbl[i].s, tbl[i].p, tbl[i].f, tbl[i].g1, tbl[i].g2);
      check_all($sformatf("row%0d", i), tbl[i].st, tbl[i].ps, tbl[i].es, tbl[i].dir,
                tbl[i].frz, tbl[i].pad, tbl[i].rec, tbl[i].win);
    end

    // Pause at SERVE frame 20, long pause, resume, 40 more frames.
    frames(30);
    check_all("pt_end", 1, 1, 1, 0, 1, 1, 1, 0);
    frames(20);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("pause_in", 4, 1, 1, 0, 1, 0, 0, 0);
    frames(100);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all("paused_hold", 4, 1, 1, 0, 1, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("pause_out", 1, 1, 1, 0, 1, 1, 0, 0);
    frames(39);
    check_all("resume39", 1, 1, 1, 0, 1, 1, 0, 0);
    frames(1);
    check_all("resume40", 2, 1, 1, 0, 0, 1, 0, 0);

    // 1:1 -> 2:1 -> 2:2, then simultaneous goals.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    frames(PF); frames(SF);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_all("s2_2", 3, 2, 2, 0, 1, 0, 0, 0);
    frames(PF); frames(SF);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_all("both_goals", 3, 3, 2, 1, 1, 0, 0, 0);

    // Player wins.
    frames(PF); frames(SF);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    frames(PF); frames(SF);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_all("win", 5, 5, 2, 1, 1, 0, 0, 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_all("over_hold", 5, 5, 2, 1, 1, 0, 0, 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all("restart", 1, 0, 0, 0, 1, 1, 1, 0);
    frames(SF);
    check_all("rally2", 2, 0, 0, 0, 0, 1, 0, 0);

    // Async reset mid-RALLY, checked between clock edges.
    #2 rst_i = 1'b1;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 1, 0, 0, 0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    model_reset();

    // ---------------- randomized run against the model ----------------
    rs = 1'b0; rp = 1'b0;
    rnd_bad = 0;
    for (int c = 0; c < 8000; c++) begin
      if ($urandom_range(0, 15) == 0) rs = ~rs;
      if ($urandom_range(0, 23) == 0) rp = ~rp;
      rf  = 1'($urandom_range(0, 1));
      rg1 = ($urandom_range(0, 9) == 0);
      rg2 = ($urandom_range(0, 9) == 0);
      cyc(rs, rp, rf, rg1, rg2);
      model_step(rs, rp, rf, rg1, rg2);
      got_v = {state_o, ball_freeze_o, ball_recenter_o, paddles_en_o, serve_dir_o,
               p_score_o, e_score_o, winner_o};
      exp_v = {3'(m_state), (m_state != 2), 1'(m_rec), (m_state == 1 || m_state == 2),
               1'(m_dir), 4'(m_p), 4'(m_e), 2'(m_win)};
      n_total++;
      if (got_v !== exp_v) begin
        n_bad++;
        rnd_bad++;
        if (rnd_bad <= 20)
          $display("FAIL rand cyc=%0d got=%h exp=%h", c, got_v, exp_v);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
